// File: rtl/gem_tmb_frame_rx_pkg.sv
// Shared TMB link definitions: K-character constants, word classes, receiver states.
// Used by both the receive deframer and the transmit framer so both ends agree on the line code.
// No logic here.
package gem_tmb_frame_rx_pkg;

  // K28.5 in the low byte, D16.2 above it: ordinary frame separator.
  localparam logic [15:0] K_SEP_BC    = 16'h50BC;
  // K28.7 in the low byte: separator that also marks a latency-trigger frame.
  localparam logic [15:0] K_SEP_FC    = 16'h50FC;
  // Idle word is two K28.5 commas, K flags on bytes 0 and 2.
  localparam logic [31:0] K_IDLE_WORD = 32'h50BC50BC;
  localparam logic [3:0]  ISK_IDLE    = 4'b0101;
  localparam logic [3:0]  ISK_SEP     = 4'b0001;
  localparam logic [3:0]  ISK_DATA    = 4'b0000;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    WC_DATA = 2'd0,
    WC_SEP  = 2'd1,
    WC_IDLE = 2'd2,
    WC_BAD  = 2'd3
  } word_class_t;

endpackage

// File: rtl/gem_tmb_word_class.sv
// Classifies one decoded GTP word as DATA, SEP, IDLE or BAD.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
module gem_tmb_word_class
  import gem_tmb_frame_rx_pkg::*;
(
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_isk,
  input  logic [3:0]  rx_disperr,
  input  logic [3:0]  rx_notintable,
  output word_class_t wclass,
  output logic        sep_is_fc
);

  logic sep_low_ok;

  // Any code-level error wins; then the K pattern decides the class.
  always_comb begin
    wclass     = WC_BAD;
    sep_low_ok = (rx_data[15:0] == K_SEP_BC) || (rx_data[15:0] == K_SEP_FC);
    sep_is_fc  = (rx_data[15:0] == K_SEP_FC);
    if ((rx_disperr | rx_notintable) != 4'b0000) begin
      wclass = WC_BAD;
    end else if ((rx_data == K_IDLE_WORD) && (rx_isk == ISK_IDLE)) begin
      wclass = WC_IDLE;
    end else if ((rx_isk == ISK_SEP) && sep_low_ok) begin
      wclass = WC_SEP;
    end else if (rx_isk == ISK_DATA) begin
      wclass = WC_DATA;
    end else begin
      wclass = WC_BAD;
    end
  end

endmodule

// File: rtl/gem_tmb_frame_rx.sv
// TMB link receiver: finds DATA+SEP frames, manages HUNT/SYNC/LOCKED, emits 48-bit payloads.
// Latency: payload and strobes registered, one cycle after the SEP word.
// Backpressure: none; the GTP stream cannot be stalled, so every word is consumed.
module gem_tmb_frame_rx
  import gem_tmb_frame_rx_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 3
) (
  input  logic        TMB_CLK80,
  input  logic        TMB_RST,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_isk,
  input  logic [3:0]  rx_disperr,
  input  logic [3:0]  rx_notintable,
  output logic [47:0] in_data,
  output logic        in_valid,
  output logic        LTNCY_TRIG,
  output logic        link_locked,
  output logic        link_idle,
  output logic [15:0] err_cnt
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [GW-1:0] GOOD_FULL = GW'(LOCK_FRAMES);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERRS - 1);

  word_class_t wclass;
  logic        sep_is_fc;

  rx_state_t   state, state_nxt;
  logic        exp_sep, exp_sep_nxt;   // next word should be the SEP of a frame
  logic [GW-1:0] good_cnt, good_nxt;
  logic [BW-1:0] bad_cnt, bad_nxt;
  logic [15:0] err_nxt;
  logic [31:0] data_q, data_nxt;       // most recent DATA word, upper part of the payload
  logic [47:0] in_data_nxt;
  logic        valid_nxt;
  logic        frame_done;             // SEP arrived right after an accepted DATA word
  logic        word_err;               // BAD or out-of-phase word while synchronising/locked

  gem_tmb_word_class u_word_class (
    .rx_data       (rx_data),
    .rx_isk        (rx_isk),
    .rx_disperr    (rx_disperr),
    .rx_notintable (rx_notintable),
    .wclass        (wclass),
    .sep_is_fc     (sep_is_fc)
  );

  assign link_locked = (state == ST_LOCKED);

  // Register all state and outputs; reset returns to HUNT and drops any half-received frame.
  always_ff @(posedge TMB_CLK80) begin
    if (TMB_RST) begin
      state      <= ST_HUNT;
      exp_sep    <= 1'b0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      err_cnt    <= 16'd0;
      data_q     <= 32'd0;
      in_data    <= 48'd0;
      in_valid   <= 1'b0;
      LTNCY_TRIG <= 1'b0;
      link_idle  <= 1'b0;
    end else begin
      state      <= state_nxt;
      exp_sep    <= exp_sep_nxt;
      good_cnt   <= good_nxt;
      bad_cnt    <= bad_nxt;
      err_cnt    <= err_nxt;
      data_q     <= data_nxt;
      in_data    <= in_data_nxt;
      in_valid   <= valid_nxt;
      LTNCY_TRIG <= (wclass == WC_SEP) && sep_is_fc;
      link_idle  <= (wclass == WC_IDLE);
    end
  end

  // Phase tracking, lock state machine and counter updates for the current word.
  always_comb begin
    state_nxt   = state;
    exp_sep_nxt = exp_sep;
    good_nxt    = good_cnt;
    bad_nxt     = bad_cnt;
    err_nxt     = err_cnt;
    frame_done  = 1'b0;
    word_err    = 1'b0;
    data_nxt    = (wclass == WC_DATA) ? rx_data : data_q;

    // Any error forces the phase back to DATA, so a SEP seen during a slip resynchronises
    // and a slipped frame never produces a payload.
    unique case (wclass)
      WC_IDLE: exp_sep_nxt = 1'b0;
      WC_DATA: begin
        if ((state == ST_HUNT) || !exp_sep) begin
          exp_sep_nxt = 1'b1;
        end else begin
          word_err    = 1'b1;
          exp_sep_nxt = 1'b0;
        end
      end
      WC_SEP: begin
        exp_sep_nxt = 1'b0;
        if (exp_sep) begin
          frame_done = 1'b1;
        end else begin
          word_err = (state != ST_HUNT);
        end
      end
      WC_BAD: begin
        exp_sep_nxt = 1'b0;
        word_err    = (state != ST_HUNT);
      end
    endcase

    case (state)
      ST_HUNT: begin
        if (frame_done) begin
          state_nxt = (LOCK_FRAMES <= 1) ? ST_LOCKED : ST_SYNC;
          good_nxt  = GW'(1);
        end
      end
      ST_SYNC: begin
        if (word_err) begin
          state_nxt = ST_HUNT;
          good_nxt  = '0;
        end else if (frame_done) begin
          if (good_cnt >= GOOD_LAST) begin
            state_nxt = ST_LOCKED;
            good_nxt  = GOOD_FULL;
          end else begin
            good_nxt = good_cnt + GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (word_err) begin
          err_nxt = (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
          if (bad_cnt >= BAD_LAST) begin
            state_nxt = ST_HUNT;
            bad_nxt   = '0;
            good_nxt  = '0;
          end else begin
            bad_nxt = bad_cnt + BW'(1);
          end
        end else if (wclass != WC_IDLE) begin
          bad_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_HUNT;
        good_nxt  = '0;
        bad_nxt   = '0;
      end
    endcase

    // The frame that completes the lock is delivered as well.
    valid_nxt   = frame_done && (state_nxt == ST_LOCKED);
    in_data_nxt = valid_nxt ? {data_q, rx_data[31:16]} : in_data;
  end

endmodule

// File: tb/tb_gem_tmb_frame_rx.sv
// Bench for the TMB link receiver: directed scenarios plus random word streams.
// Latency: outputs compared 1 ns after each rising edge.
// Backpressure: not applicable.
module tb_gem_tmb_frame_rx;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  de;
    logic [3:0]  nit;
  } rxw_t;

  localparam int C_DATA = 0, C_SEP = 1, C_IDLE = 2, C_BAD = 3;
  localparam int LOCK_N = 4, UNLOCK_N = 3;
  localparam logic [47:0] P_BASE = 48'h123456789ABC;

  logic        clk = 1'b0;
  logic        TMB_RST;
  logic [31:0] rx_data;
  logic [3:0]  rx_isk, rx_disperr, rx_notintable;
  logic [47:0] in_data, in_data_s;
  logic        in_valid, in_valid_s, LTNCY_TRIG, LTNCY_TRIG_s;
  logic        link_locked, link_locked_s, link_idle, link_idle_s;
  logic [15:0] err_cnt, err_cnt_s;

  always #5 clk = ~clk;

  gem_tmb_frame_rx dut (
    .TMB_CLK80(clk), .TMB_RST(TMB_RST), .rx_data(rx_data), .rx_isk(rx_isk),
    .rx_disperr(rx_disperr), .rx_notintable(rx_notintable), .in_data(in_data),
    .in_valid(in_valid), .LTNCY_TRIG(LTNCY_TRIG), .link_locked(link_locked),
    .link_idle(link_idle), .err_cnt(err_cnt)
  );

  // Tolerant instance: never unlocks, so the error counter can be driven to saturation.
  gem_tmb_frame_rx #(.LOCK_FRAMES(4), .UNLOCK_ERRS(100000)) dut_sat (
    .TMB_CLK80(clk), .TMB_RST(TMB_RST), .rx_data(rx_data), .rx_isk(rx_isk),
    .rx_disperr(rx_disperr), .rx_notintable(rx_notintable), .in_data(in_data_s),
    .in_valid(in_valid_s), .LTNCY_TRIG(LTNCY_TRIG_s), .link_locked(link_locked_s),
    .link_idle(link_idle_s), .err_cnt(err_cnt_s)
  );

  int total = 0;
  int n_bad = 0;
  int n_valid_seen = 0;
  bit chk_each = 1'b1;

  // Reference model state
  int          m_state;      // 0 hunt, 1 sync, 2 locked
  bit          m_want_sep;
  int          m_good, m_bad, m_err;
  logic [31:0] m_held;
  logic [47:0] m_in_data;
  bit          m_valid, m_trig, m_idle;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input rxw_t w);
    if ((w.de | w.nit) != 4'b0000) return C_BAD;
    if (w.d == 32'h50BC50BC && w.k == 4'b0101) return C_IDLE;
    if (w.k == 4'b0001 && (w.d[15:0] == 16'h50BC || w.d[15:0] == 16'h50FC)) return C_SEP;
    if (w.k == 4'b0000) return C_DATA;
    return C_BAD;
  endfunction

  function automatic rxw_t w_data(input logic [31:0] d);
    rxw_t w;
    w.d = d; w.k = 4'b0000; w.de = 4'b0000; w.nit = 4'b0000;
    return w;
  endfunction

  function automatic rxw_t w_sep(input logic [15:0] hi, input bit fc);
    rxw_t w;
    w.d = {hi, fc ? 16'h50FC : 16'h50BC}; w.k = 4'b0001; w.de = 4'b0000; w.nit = 4'b0000;
    return w;
  endfunction

  function automatic rxw_t w_idle();
    rxw_t w;
    w.d = 32'h50BC50BC; w.k = 4'b0101; w.de = 4'b0000; w.nit = 4'b0000;
    return w;
  endfunction

  function automatic rxw_t w_rand_bad();
    rxw_t w;
    w = w_data($urandom);
    case ($urandom_range(0, 3))
      0:       w.de  = 4'(1 << $urandom_range(0, 3));
      1:       w.nit = 4'(1 << $urandom_range(0, 3));
      2:       w.k   = 4'b1010;
      default: begin w.k = 4'b0001; w.d[15:0] = 16'h1234; end
    endcase
    return w;
  endfunction

  // Frame rules: a frame is an in-phase DATA then SEP; errors only matter once synchronising.
  task automatic model_step(input rxw_t w, input bit rst);
    int  cls;
    bit  completes, is_err;
    if (rst) begin
      m_state = 0; m_want_sep = 0; m_good = 0; m_bad = 0; m_err = 0;
      m_held = '0; m_in_data = '0; m_valid = 0; m_trig = 0; m_idle = 0;
      return;
    end
    cls       = classify(w);
    completes = 0;
    is_err    = 0;
    m_valid   = 0;
    m_trig    = (cls == C_SEP) && (w.d[15:0] == 16'h50FC);
    m_idle    = (cls == C_IDLE);
    if (cls == C_IDLE) m_want_sep = 0;
    else if (cls == C_DATA && (m_state == 0 || !m_want_sep)) m_want_sep = 1;
    else if (cls == C_SEP && m_want_sep) begin completes = 1; m_want_sep = 0; end
    else begin is_err = (m_state != 0); m_want_sep = 0; end

    if (m_state == 0) begin
      if (completes) begin m_good = 1; m_state = 1; end
    end else if (m_state == 1) begin
      if (is_err) begin m_state = 0; m_good = 0; end
      else if (completes) begin
        m_good++;
        if (m_good >= LOCK_N) m_state = 2;
      end
    end else begin
      if (is_err) begin
        if (m_err < 65535) m_err++;
        m_bad++;
        if (m_bad >= UNLOCK_N) begin m_state = 0; m_bad = 0; m_good = 0; end
      end else if (cls != C_IDLE) m_bad = 0;
    end
    if (completes && m_state == 2) begin
      m_valid   = 1;
      m_in_data = {m_held, w.d[31:16]};
    end
    if (cls == C_DATA) m_held = w.d;
  endtask

  task automatic step(input rxw_t w, input bit rst);
    rx_data = w.d; rx_isk = w.k; rx_disperr = w.de; rx_notintable = w.nit; TMB_RST = rst;
    @(posedge clk);
    model_step(w, rst);
    #1;
    if (in_valid === 1'b1) n_valid_seen++;
    if (chk_each) begin
      chk("in_valid",    48'(in_valid),    48'(m_valid));
      chk("in_data",     in_data,          m_in_data);
      chk("LTNCY_TRIG",  48'(LTNCY_TRIG),  48'(m_trig));
      chk("link_locked", 48'(link_locked), 48'(m_state == 2));
      chk("link_idle",   48'(link_idle),   48'(m_idle));
      chk("err_cnt",     48'(err_cnt),     48'(m_err));
    end
  endtask

  task automatic send_frame(input logic [47:0] p, input bit fc);
    step(w_data(p[47:16]), 1'b0);
    step(w_sep(p[15:0], fc), 1'b0);
  endtask

  initial begin
    rxw_t        w;
    logic [47:0] p;
    int          r;

    // Reset state
    step(w_idle(), 1'b1);
    step(w_idle(), 1'b1);
    chk("rst_in_data", in_data, 48'd0);
    chk("rst_in_valid", 48'(in_valid), 48'd0);
    chk("rst_trig", 48'(LTNCY_TRIG), 48'd0);
    chk("rst_locked", 48'(link_locked), 48'd0);
    chk("rst_idle", 48'(link_idle), 48'd0);
    chk("rst_err", 48'(err_cnt), 48'd0);

    // Idle then four frames: lock on the fourth SEP with exactly one payload
    for (int i = 0; i < 10; i++) step(w_idle(), 1'b0);
    chk("idle_high", 48'(link_idle), 48'd1);
    n_valid_seen = 0;
    for (int i = 1; i <= 4; i++) begin
      send_frame(P_BASE + 48'(i), 1'b0);
      if (i == 3) chk("not_locked_at_3", 48'(link_locked), 48'd0);
    end
    chk("locked_at_4", 48'(link_locked), 48'd1);
    chk("lock_valid", 48'(in_valid), 48'd1);
    chk("lock_data", in_data, P_BASE + 48'd4);
    chk("lock_one_valid", 48'(n_valid_seen), 48'd1);
    chk("idle_low", 48'(link_idle), 48'd0);

    // Latency trigger frame
    send_frame(P_BASE + 48'd5, 1'b0);
    send_frame(P_BASE + 48'd6, 1'b1);
    chk("trig_hi", 48'(LTNCY_TRIG), 48'd1);
    chk("trig_valid", 48'(in_valid), 48'd1);
    chk("trig_data", in_data, P_BASE + 48'd6);
    step(w_data(32'hCAFE0001), 1'b0);
    chk("trig_pulse", 48'(LTNCY_TRIG), 48'd0);
    chk("hold_data", in_data, P_BASE + 48'd6);
    step(w_sep(16'h0002, 1'b0), 1'b0);

    // Two disparity errors tolerated, three drop lock
    p = P_BASE + 48'd7;
    w = w_data(p[47:16]); w.de = 4'b0001; step(w, 1'b0);
    w = w_sep(p[15:0], 1'b0); w.de = 4'b0001; step(w, 1'b0);
    send_frame(p, 1'b0);
    chk("err_plus2", 48'(err_cnt), 48'd2);
    chk("stay_locked", 48'(link_locked), 48'd1);
    chk("after_err_data", in_data, p);
    w = w_data(p[47:16]); w.de = 4'b0001; step(w, 1'b0);
    w = w_sep(p[15:0], 1'b0); w.de = 4'b0001; step(w, 1'b0);
    w = w_data(p[47:16]); w.de = 4'b0001; step(w, 1'b0);
    chk("unlock", 48'(link_locked), 48'd0);
    chk("err_plus3", 48'(err_cnt), 48'd5);

    // Relock, then slip one word
    for (int i = 10; i < 14; i++) send_frame(P_BASE + 48'(i), 1'b0);
    chk("relock", 48'(link_locked), 48'd1);
    n_valid_seen = 0;
    p = P_BASE + 48'd20;
    step(w_data(p[47:16]), 1'b0);
    p = P_BASE + 48'd21;
    step(w_data(p[47:16]), 1'b0);
    step(w_sep(p[15:0], 1'b0), 1'b0);
    chk("slip_no_valid", 48'(n_valid_seen), 48'd0);
    chk("slip_err", 48'(err_cnt), 48'd7);
    send_frame(P_BASE + 48'd22, 1'b0);
    chk("resync_valid", 48'(in_valid), 48'd1);
    chk("resync_data", in_data, P_BASE + 48'd22);
    chk("slip_locked", 48'(link_locked), 48'd1);

    // Reset between DATA and SEP
    p = P_BASE + 48'd30;
    step(w_data(p[47:16]), 1'b0);
    step(w_sep(p[15:0], 1'b0), 1'b1);
    chk("mid_rst_data", in_data, 48'd0);
    chk("mid_rst_valid", 48'(in_valid), 48'd0);
    chk("mid_rst_locked", 48'(link_locked), 48'd0);
    chk("mid_rst_err", 48'(err_cnt), 48'd0);
    n_valid_seen = 0;
    step(w_sep(p[15:0], 1'b0), 1'b0);
    step(w_idle(), 1'b0);
    chk("mid_rst_no_frame", 48'(n_valid_seen), 48'd0);

    // Random word stream against the model
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        p[47:16] = $urandom;
        p[15:0]  = 16'($urandom);
        send_frame(p, ($urandom_range(0, 9) == 0));
      end else if (r < 78) step(w_idle(), 1'b0);
      else if (r < 85) step(w_rand_bad(), 1'b0);
      else if (r < 92) step(w_data($urandom), 1'b0);
      else step(w_sep(16'($urandom), $urandom_range(0, 1) == 1), 1'b0);
    end

    // Error counter saturation on the tolerant instance
    chk_each = 1'b0;
    step(w_idle(), 1'b1);
    for (int i = 1; i <= 4; i++) send_frame(P_BASE + 48'(i), 1'b0);
    chk("sat_locked", 48'(link_locked_s), 48'd1);
    w = w_data(32'h0BAD0BAD); w.de = 4'b0001;
    for (int i = 0; i < 65534; i++) step(w, 1'b0);
    chk("sat_fffe", 48'(err_cnt_s), 48'hFFFE);
    for (int i = 0; i < 466; i++) step(w, 1'b0);
    chk("sat_ffff", 48'(err_cnt_s), 48'hFFFF);
    chk("sat_still_locked", 48'(link_locked_s), 48'd1);
    chk("sat_dut_err", 48'(err_cnt), 48'd3);
    chk("sat_dut_unlocked", 48'(link_locked), 48'd0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule

// File: doc/gem_tmb_frame_rx.md
GEM_TMB_FRAME_RX -- requirements
Module: gem_tmb_frame_rx

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 4, meaning consecutive good frames needed to declare lock.
REQ-002 SHALL have parameter UNLOCK_ERRS, default 3, meaning consecutive bad words needed to drop lock.
REQ-003 SHALL have port TMB_CLK80  in  1  the only clock (RXUSRCLK2 domain, 80 MHz LHC-locked).
REQ-004 SHALL have port TMB_RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rx_data  in  32  GTP RX decoded word.
REQ-006 SHALL have port rx_isk  in  4  GTP RX char-is-K flags, bit n for byte n.
REQ-007 SHALL have port rx_disperr  in  4  GTP RX disparity error per byte.
REQ-008 SHALL have port rx_notintable  in  4  GTP RX not-in-table per byte.
REQ-009 SHALL have port in_data  out  48  reassembled frame payload.
REQ-010 SHALL have port in_valid  out  1  one-cycle strobe qualifying in_data.
REQ-011 SHALL have port LTNCY_TRIG  out  1  one-cycle strobe on K28.7 separator frame.
REQ-012 SHALL have port link_locked  out  1  high in LOCKED state.
REQ-013 SHALL have port link_idle  out  1  high while idle words are received.
REQ-014 SHALL have port err_cnt  out  16  saturating count of bad words seen in LOCKED.

Function
REQ-015 Each cycle SHALL classify the input word: BAD if any rx_disperr or rx_notintable bit set; else IDLE if rx_data==0x50BC50BC and rx_isk==4'b0101; else SEP if rx_isk==4'b0001 and rx_data[15:0] is 0x50BC or 0x50FC; else DATA if rx_isk==4'b0000; else BAD.
REQ-016 A frame SHALL be a DATA word followed on the next cycle by a SEP word; payload = {DATA[31:0], SEP[31:16]}.
REQ-017 States SHALL be HUNT, SYNC, LOCKED; reset state HUNT.
REQ-018 HUNT: on a frame -> SYNC with good count 1; any other word stays in HUNT.
REQ-019 SYNC/LOCKED SHALL track expected phase (DATA then SEP, alternating); a word matching expected phase is good.
REQ-020 SYNC: each completed frame increments good count; at LOCK_FRAMES -> LOCKED; any phase mismatch or BAD word -> HUNT, count cleared.
REQ-021 LOCKED: phase mismatch or BAD word increments bad count and err_cnt; UNLOCK_ERRS consecutive -> HUNT; any good word clears bad count.
REQ-022 IDLE word in any state SHALL force expected phase to DATA, assert link_idle next cycle, and count neither good nor bad; link_idle deasserts on the first non-IDLE word.
REQ-023 in_data/in_valid SHALL be registered: valid asserted exactly one cycle after the SEP word, only in LOCKED (including the frame that completes the lock).
REQ-024 in_data SHALL hold its last value when in_valid is low.
REQ-025 LTNCY_TRIG SHALL assert with in_valid when the SEP low half was 0x50FC, regardless of lock.
REQ-026 A SEP word accepted while a mismatch is being counted SHALL resynchronise phase (expect DATA next).
REQ-027 err_cnt SHALL saturate at 0xFFFF and never wrap.
REQ-028 Good and bad counters SHALL saturate at their thresholds.

Reset
REQ-029 TMB_RST high SHALL, on the next clock edge, set state HUNT, all counters 0, in_data 0, in_valid 0, LTNCY_TRIG 0, link_locked 0, link_idle 0, err_cnt 0.
REQ-030 Reset mid-frame SHALL discard the pending DATA word; no in_valid for it after reset releases.

Structure
REQ-031 Shared package SHALL hold the K/idle constants (0x50BC, 0x50FC, 0x50BC50BC, isk patterns) and the state and word-class enumerations, shared with the transmit framer.
REQ-032 One sub-module gem_tmb_word_class SHALL implement the combinational word classifier; the remainder is a single FSM module.

Verification
REQ-033 Idle 0x50BC50BC x10 then 4 frames with payloads 0x123456789ABC.. -> link_idle high during idle, link_locked after 4th SEP, one in_valid with in_data=4th payload.
REQ-034 Locked stream, SEP low half 0x50FC on one frame -> LTNCY_TRIG and in_valid high same cycle, payload intact.
REQ-035 Locked, inject rx_disperr=4'b0001 on 2 consecutive words then good -> err_cnt +2, stays locked; 3 consecutive -> link_locked low, state HUNT.
REQ-036 Locked, drop one word (phase slip) -> mismatch counted, resync on next SEP, no in_valid with corrupted payload.
REQ-037 Assert TMB_RST between DATA and SEP words -> all outputs 0 next cycle, no in_valid for that frame.
REQ-038 Force 70000 bad words while locked/relocking -> err_cnt holds 0xFFFF.
